// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: receiver state encoding,
// data width and the clock-divider helper used to derive bit timing.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    // Clocks per bit, rounded to the nearest integer.
    function automatic int unsigned baud_div(input int unsigned clk_freq, input int unsigned baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with push/pop arbitration.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write request and byte; dropped when full unless popping
//   pop                 read request; ignored while empty
//   head                registered copy of the oldest entry, valid while not_empty
//   not_empty, full     registered occupancy flags
//   count               entries held, 0..DEPTH
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     not_empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_ptr_n;
    logic [CW-1:0]    count_n;
    logic             do_push_c;
    logic             do_pop_c;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept a push.
    always_comb begin
        do_pop_c  = pop && not_empty;
        do_push_c = push && (!full || do_pop_c);
        rd_ptr_n  = rd_ptr + PW'(do_pop_c);
        count_n   = count + CW'(do_push_c) - CW'(do_pop_c);
    end

    // Storage array.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and head register; the head bypasses the array when
    // the byte being written lands in the slot that becomes the new head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            not_empty <= 1'b0;
            full      <= 1'b0;
            head      <= '0;
        end else begin
            wr_ptr    <= wr_ptr + PW'(do_push_c);
            rd_ptr    <= rd_ptr_n;
            count     <= count_n;
            not_empty <= (count_n != '0);
            full      <= (count_n == CW'(DEPTH));
            if (do_push_c && (wr_ptr == rd_ptr_n)) begin
                head <= push_data;
            end else begin
                head <= mem[rd_ptr_n];
            end
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 serial receiver with a show-ahead receive FIFO and sticky error flags.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   rxd                 raw serial input, idle high
//   rd_en               pop strobe, one byte per asserted cycle
//   rd_data             FIFO head byte, valid while rx_valid
//   rx_valid, rx_count  FIFO not empty, bytes held
//   frame_err           sticky: stop bit sampled low
//   overrun             sticky: byte dropped because the FIFO was full
//   clr_err             synchronous clear of both sticky flags
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 59000000,
    parameter int unsigned BAUD     = 9600,
    parameter int unsigned DEPTH    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rxd,
    input  logic                        rd_en,
    output logic [UART_DATA_BITS-1:0]   rd_data,
    output logic                        rx_valid,
    output logic [$clog2(DEPTH):0]      rx_count,
    output logic                        frame_err,
    output logic                        overrun,
    input  logic                        clr_err
);

    localparam int unsigned BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int unsigned HALF_DIV = BAUD_DIV / 2;
    localparam int unsigned CNT_W    = $clog2(BAUD_DIV);
    localparam int unsigned BIT_W    = $clog2(UART_DATA_BITS);

    logic                       rxd_meta;
    logic                       rxd_s;
    rx_state_e                  state;
    logic [CNT_W-1:0]           cnt;
    logic [BIT_W-1:0]           bit_idx;
    logic [UART_DATA_BITS-1:0]  shift;
    logic                       stop_tick_c;
    logic                       push_c;
    logic                       ferr_set_c;
    logic                       ovr_set_c;
    logic                       fifo_full;

    // Two-flop synchroniser; resets to the idle line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
        end
    end

    // Stop-bit sample outcome; a same-cycle pop makes room, so no overrun then.
    always_comb begin
        stop_tick_c = (state == STOP) && (cnt == CNT_W'(BAUD_DIV - 1));
        push_c      = stop_tick_c && rxd_s;
        ferr_set_c  = stop_tick_c && !rxd_s;
        ovr_set_c   = push_c && fifo_full && !rd_en;
    end

    // Bit-timing FSM: mid-bit start check, then full-bit steps to each sample.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_W'(HALF_DIV - 1)) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxd_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_W'(BAUD_DIV - 1)) begin
                        cnt   <= '0;
                        shift <= {rxd_s, shift[UART_DATA_BITS-1:1]};
                        if (bit_idx == BIT_W'(UART_DATA_BITS - 1)) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (stop_tick_c) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (ferr_set_c) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ovr_set_c) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst),
        .push      (push_c),
        .push_data (shift),
        .pop       (rd_en),
        .head      (rd_data),
        .not_empty (rx_valid),
        .full      (fifo_full),
        .count     (rx_count)
    );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo (16 clocks per bit, 16-entry FIFO).
module tb_uart_rx_fifo;

    localparam int unsigned CLK_FREQ   = 160;
    localparam int unsigned BAUD       = 10;
    localparam int          DEPTH      = 16;
    localparam int          BIT_CLKS   = 16;
    localparam int          FRAME_CLKS = 160;
    // Iteration (clocks after the start-bit edge) whose following edge takes the
    // stop sample: 2 sync clocks + 1 detect + 8 half-bit + 9 bit times - 1.
    localparam int          PUSH_ITER  = 154;

    logic       clk;
    logic       rst;
    logic       rxd;
    logic       rd_en;
    logic       clr_err;
    logic [7:0] rd_data;
    logic       rx_valid;
    logic [4:0] rx_count;
    logic       frame_err;
    logic       overrun;

    int n_checks;
    int n_fail;

    // Reference model: queue of held bytes plus sticky flags.
    logic [7:0] q[$];
    bit         m_ferr;
    bit         m_ovr;
    logic [7:0] exp_pops[$];
    logic [7:0] obs_pops[$];

    uart_rx_fifo #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rxd       (rxd),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .rx_valid  (rx_valid),
        .rx_count  (rx_count),
        .frame_err (frame_err),
        .overrun   (overrun),
        .clr_err   (clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drive one frame; pop_at < 0 means no pop, abort_at < 0 means full frame.
    task automatic send_frame(input logic [7:0] data, input logic stop,
                              input int pop_at, input int abort_at);
        logic [9:0] bits;
        bits = {stop, data, 1'b0};
        for (int c = 0; c < FRAME_CLKS; c++) begin
            @(posedge clk);
            #1;
            if (c == abort_at) begin
                rxd   = 1'b1;
                rd_en = 1'b0;
                return;
            end
            rxd   = bits[4'(c / BIT_CLKS)];
            rd_en = (c == pop_at);
            if (c == pop_at && q.size() > 0) begin
                exp_pops.push_back(q.pop_front());
                obs_pops.push_back(rd_data);
            end
            if (c == PUSH_ITER) begin
                if (!stop)                 m_ferr = 1'b1;
                else if (q.size() < DEPTH) q.push_back(data);
                else                       m_ovr = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        rxd   = 1'b1;
        idle(16);
    endtask

    task automatic pop_byte(output logic [7:0] d, output logic v);
        @(posedge clk);
        #1;
        d     = rd_data;
        v     = rx_valid;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
    endtask

    task automatic clear_errors();
        @(posedge clk);
        #1;
        clr_err = 1'b1;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
        m_ferr  = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic apply_reset();
        rst     = 1'b0;
        rxd     = 1'b1;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        idle(3);
        rst = 1'b1;
        q.delete();
        exp_pops.delete();
        obs_pops.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        idle(2);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", rx_count); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", rd_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_ovr: got %b expected 0", overrun); end
    endtask

    task automatic test_single_frame();
        logic [7:0] d;
        logic       v;
        send_frame(8'h55, 1'b1, -1, -1);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b expected 1", rx_valid); end
        n_checks++; if (rd_data !== 8'h55) begin n_fail++; $display("FAIL single_data: got %h expected 55", rd_data); end
        n_checks++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", rx_count); end
        pop_byte(d, v);
        void'(q.pop_front());
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL single_pop_count: got %0d expected 0", rx_count); end
        // Pop on an empty FIFO is ignored.
        pop_byte(d, v);
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL underflow_count: got %0d expected 0", rx_count); end
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #1;
        rxd = 1'b0;
        idle(4);
        rxd = 1'b1;
        idle(200);
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", rx_count); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_ferr: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL glitch_ovr: got %b expected 0", overrun); end
    endtask

    task automatic test_frame_error();
        logic [7:0] d;
        logic       v;
        send_frame(8'hA5, 1'b0, -1, -1);
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL ferr_count: got %0d expected 0", rx_count); end
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
        clear_errors();
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clear: got %b expected 0", frame_err); end
        send_frame(8'h3C, 1'b1, -1, -1);
        n_checks++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL ferr_next_count: got %0d expected 1", rx_count); end
        pop_byte(d, v);
        void'(q.pop_front());
        n_checks++; if (d !== 8'h3C) begin n_fail++; $display("FAIL ferr_next_data: got %h expected 3c", d); end
    endtask

    task automatic test_overrun();
        logic [7:0] d;
        logic       v;
        for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1, -1, -1);
        send_frame(8'hFF, 1'b1, -1, -1);
        n_checks++; if (rx_count !== 5'd16) begin n_fail++; $display("FAIL ovr_count: got %0d expected 16", rx_count); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        for (int i = 0; i < 16; i++) begin
            pop_byte(d, v);
            void'(q.pop_front());
            n_checks++; if (d !== 8'(i) || v !== 1'b1) begin n_fail++; $display("FAIL ovr_drain[%0d]: got %h valid %b expected %h valid 1", i, d, v, 8'(i)); end
        end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_empty: got %b expected 0", rx_valid); end
        clear_errors();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
    endtask

    task automatic test_full_pop();
        logic [7:0] d;
        logic       v;
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) send_frame(8'($urandom), 1'b1, -1, -1);
        send_frame(8'h77, 1'b1, PUSH_ITER, -1);
        n_checks++; if (rx_count !== 5'd16) begin n_fail++; $display("FAIL fullpop_count: got %0d expected 16", rx_count); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fullpop_ovr: got %b expected 0", overrun); end
        n_checks++; if (obs_pops.size() != 1 || obs_pops[0] !== exp_pops[0]) begin n_fail++; $display("FAIL fullpop_popped: got %0d pops expected 1 matching", obs_pops.size()); end
        obs_pops.delete();
        exp_pops.delete();
        for (int i = 0; i < 16; i++) begin
            pop_byte(d, v);
            exp = q.pop_front();
            n_checks++; if (d !== exp) begin n_fail++; $display("FAIL fullpop_drain[%0d]: got %h expected %h", i, d, exp); end
        end
        n_checks++; if (d !== 8'h77) begin n_fail++; $display("FAIL fullpop_last: got %h expected 77", d); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL fullpop_empty: got %b expected 0", rx_valid); end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] d;
        logic       v;
        // Clocks 80..95 carry data bit 4.
        send_frame(8'h12, 1'b1, -1, 88);
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        idle(5);
        send_frame(8'h9A, 1'b1, -1, -1);
        n_checks++; if (rx_count !== 5'd1) begin n_fail++; $display("FAIL midrst_count: got %0d expected 1", rx_count); end
        n_checks++; if (rd_data !== 8'h9A) begin n_fail++; $display("FAIL midrst_data: got %h expected 9a", rd_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL midrst_ferr: got %b expected 0", frame_err); end
        pop_byte(d, v);
        void'(q.pop_front());
    endtask

    task automatic test_break();
        logic [7:0] d;
        logic       v;
        // Two back-to-back break frames, released before the third start check.
        @(posedge clk);
        #1;
        rxd = 1'b0;
        idle(310);
        rxd = 1'b1;
        m_ferr = 1'b1;
        idle(60);
        n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b expected 1", frame_err); end
        n_checks++; if (rx_count !== 5'd0) begin n_fail++; $display("FAIL break_count: got %0d expected 0", rx_count); end
        clear_errors();
        send_frame(8'hC3, 1'b1, -1, -1);
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL break_rearm_ferr: got %b expected 0", frame_err); end
        pop_byte(d, v);
        void'(q.pop_front());
        n_checks++; if (d !== 8'hC3) begin n_fail++; $display("FAIL break_rearm_data: got %h expected c3", d); end
    endtask

    task automatic test_random();
        logic [7:0] d;
        logic       v;
        logic [7:0] exp;
        int         pop_at;
        int         r;
        apply_reset();
        for (int n = 0; n < 30; n++) begin
            r = int'($urandom_range(0, 5));
            if (r <= 2)      pop_at = -1;
            else if (r == 3) pop_at = PUSH_ITER;
            else if (r == 4) pop_at = int'($urandom_range(0, 150));
            else             pop_at = int'($urandom_range(156, 158));
            send_frame(8'($urandom), ($urandom_range(0, 7) != 0), pop_at, -1);
            n_checks++; if (rx_count !== 5'(q.size()) || frame_err !== m_ferr || overrun !== m_ovr) begin
                n_fail++;
                $display("FAIL rand_state[%0d]: got count %0d ferr %b ovr %b expected %0d %b %b",
                         n, rx_count, frame_err, overrun, q.size(), m_ferr, m_ovr);
            end
            if ($urandom_range(0, 9) == 0) clear_errors();
        end
        n_checks++; if (obs_pops.size() != exp_pops.size()) begin n_fail++; $display("FAIL rand_pop_count: got %0d expected %0d", obs_pops.size(), exp_pops.size()); end
        for (int i = 0; i < obs_pops.size() && i < exp_pops.size(); i++) begin
            n_checks++; if (obs_pops[i] !== exp_pops[i]) begin n_fail++; $display("FAIL rand_pop[%0d]: got %h expected %h", i, obs_pops[i], exp_pops[i]); end
        end
        while (q.size() > 0) begin
            pop_byte(d, v);
            exp = q.pop_front();
            n_checks++; if (d !== exp || v !== 1'b1) begin n_fail++; $display("FAIL rand_drain: got %h valid %b expected %h valid 1", d, v, exp); end
        end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty: got %b expected 0", rx_valid); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_frame();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_full_pop();
        test_reset_midframe();
        test_break();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
